fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the transferred-word counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: permits new FIFO reads while high.
REQ-006 SHALL have port rempty, input, 1 bit: FIFO empty flag; high means no word may be read.
REQ-007 SHALL have port rinc, output, 1 bit: FIFO read strobe; one word consumed per cycle with rinc=1.
REQ-008 SHALL have port rdata, input, WIDTH bits: FIFO read data, valid exactly 1 cycle after the rinc cycle.
REQ-009 SHALL have port m_valid, output, 1 bit: output word available.
REQ-010 SHALL have port m_ready, input, 1 bit: sink accepts the word; transfer = m_valid & m_ready.
REQ-011 SHALL have port m_data, output, WIDTH bits: output word.
REQ-012 SHALL have port xfer_cnt, output, CNT_W bits: count of completed output transfers.
REQ-013 Clock is clk, reset is rst; one clock domain, reset asynchronous and active-high.

Function
REQ-014 SHALL keep a 2-entry output buffer (head drives m_data) plus an in-flight flag for a read issued last cycle.
REQ-015 SHALL define occ = buffered entries (0..2) + in-flight (0..1); occ SHALL never exceed 2.
REQ-016 SHALL assert rinc combinationally iff en & !rempty & !rst & (occ<2 | (occ==2 & m_valid & m_ready)).
REQ-017 SHALL set in-flight in the cycle after rinc=1 and capture rdata into the buffer tail at that edge+1, i.e. read latency 1 cycle.
REQ-018 SHALL assert m_valid iff the buffer holds >=1 entry; minimum latency from rinc to m_valid is 2 cycles.
REQ-019 SHALL deliver words in exactly the order read from the FIFO; no drop, no duplication.
REQ-020 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-021 SHALL, on simultaneous capture and transfer, pop head and push tail in the same cycle with no bubble.
REQ-022 SHALL sustain one word per cycle when rempty=0, en=1, and m_ready=1 continuously.
REQ-023 SHALL, with en=0, issue no new rinc but still capture any in-flight word and keep draining the buffer.
REQ-024 SHALL ignore rdata in cycles with no in-flight read.
REQ-025 SHALL increment xfer_cnt by 1 per transfer, wrapping modulo 2^CNT_W (0xFFFF -> 0x0000 for default).
REQ-026 SHALL ignore m_ready when m_valid=0.

Reset
REQ-027 SHALL, while rst=1, force rinc=0, m_valid=0, m_data=0, xfer_cnt=0, buffer empty, in-flight clear, independent of clk.
REQ-028 SHALL discard any in-flight or buffered word on reset mid-operation; the FIFO SHALL be reset together with this block.
REQ-029 SHALL allow rinc in the first clk edge after rst deasserts if en=1 and rempty=0.

Verification
REQ-030 Reset then FIFO with 0x11,0x22,0x33, en=1, m_ready=1 -> rinc at cycles 0,1,2; m_data 0x11,0x22,0x33 at cycles 2,3,4; xfer_cnt=3.
REQ-031 Same FIFO contents, m_ready=0 -> exactly 2 rinc pulses, m_valid=1, m_data=0x11 held; raise m_ready -> 0x11,0x22,0x33 follow in order.
REQ-032 Random m_ready (50%) over 1000 words from an 8-bit counter source -> output sequence identical to input, occ never >2, no rinc while rempty=1.
REQ-033 en dropped while 1 read in flight -> that word still delivered, no further rinc until en=1.
REQ-034 rst pulsed with 2 buffered words and 1 in flight -> m_valid=0, xfer_cnt=0 immediately; after release, next output is first word written post-reset.
REQ-035 Preload xfer_cnt to 0xFFFE via 0xFFFE transfers, then 3 more -> xfer_cnt reads 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// FIFO read side to valid/ready stream adapter with one-cycle read latency.
// A two-entry skid buffer plus one in-flight read keeps full throughput under backpressure.
module fifo_rd_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             rempty,
   output logic             rinc,
   input  logic [WIDTH-1:0] rdata,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] xfer_cnt
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             inflight_q;
   logic [1:0]       occ;
   logic             pop;
   logic             push;

   // Occupancy counts the read already issued, so a full buffer never overflows.
   assign occ     = cnt_q + {1'b0, inflight_q};
   assign m_valid = (cnt_q != 2'd0);
   assign m_data  = head_q;
   assign pop     = m_valid & m_ready;
   assign push    = inflight_q;

   // A pop in the same cycle frees the slot the new read will land in.
   assign rinc = en & ~rempty & ~rst &
                 ((occ < 2'd2) | ((occ == 2'd2) & pop));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      unique case ({pop, push})
         2'b01: begin
            if (cnt_q == 2'd0) head_d = rdata;
            else               tail_d = rdata;
            cnt_d = cnt_q + 2'd1;
         end
         2'b10: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // Pop and push together: the count is unchanged and no bubble appears.
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
               tail_d = rdata;
            end else begin
               head_d = rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data registers are reset too, because m_data must read zero during reset.
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= 2'd0;
         inflight_q <= 1'b0;
         xfer_cnt   <= '0;
      end else begin
         // NOTE: non-blocking updates, so every register samples the pre-edge values.
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         inflight_q <= rinc;
         if (pop) xfer_cnt <= xfer_cnt + 1'b1;
      end
   end

endmodule
